awg_playback_buffer: RTL and testbench



---
 rtl/tx_pkg.sv | 16 +
 rtl/dma_row_packer.sv | 52 +++++
 rtl/awg_playback_buffer.sv | 194 +++++++++++++++++++
 tb/tb_awg_playback_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state encoding and bit indices for the AWG playback buffer
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    PLAYING = 2'd3
  } awg_state_t;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_PARTIAL  = 1;
  localparam int TRIG_START   = 0;
  localparam int TRIG_STOP    = 1;

endpackage

// File: rtl/dma_row_packer.sv
// rtl/dma_row_packer.sv - assembles DMA beats into little-endian rows, zero-pads on early last
module dma_row_packer #(
  parameter int ROW_W = 64,
  parameter int AXI_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AXI_W-1:0] beat_data_i,
  input  logic             beat_accept_i,
  input  logic             beat_last_i,
  output logic             row_wr_o,
  output logic [ROW_W-1:0] row_data_o,
  output logic             partial_o
);

  localparam int BEATS = ROW_W / AXI_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             full;

  assign full = (cnt_q == CW'(BEATS - 1));

  // Unfilled slots of row_q are always zero, so an early last pads for free.
  always_comb begin
    row_data_o = row_q;
    row_data_o[cnt_q*AXI_W +: AXI_W] = beat_data_i;
    row_wr_o  = beat_accept_i && (full || beat_last_i);
    partial_o = beat_accept_i && beat_last_i && !full;
    cnt_d = cnt_q;
    row_d = row_q;
    if (row_wr_o) begin
      cnt_d = '0;
      row_d = '0;
    end else if (beat_accept_i) begin
      cnt_d = cnt_q + CW'(1);
      row_d = row_data_o;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/awg_playback_buffer.sv
// rtl/awg_playback_buffer.sv - DMA-loaded row buffer replayed to the DAC on trigger
// AWG_PLAYBACK_MARKER_EN adds marker_out, a pulse aligned with row 0 of each repetition.
module awg_playback_buffer
  import tx_pkg::*;
#(
  parameter int CHANNELS         = 8,
  parameter int DEPTH            = 4096,
  parameter int AXI_MM_WIDTH     = 128,
  parameter int PARALLEL_SAMPLES = 16,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int BURST_WIDTH      = 16
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [AXI_MM_WIDTH-1:0]                         dma_in_data,
  input  logic                                            dma_in_valid,
  input  logic                                            dma_in_last,
  output logic                                            dma_in_ready,
  output logic [CHANNELS*PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] dac_out_data,
  output logic [CHANNELS-1:0]                             dac_out_valid,
  input  logic [1:0]                                      trigger_in_data,
  input  logic                                            trigger_in_valid,
  input  logic [BURST_WIDTH-1:0]                          burst_in_data,
  input  logic                                            burst_in_valid,
  output logic [1:0]                                      error_out_data,
  output logic                                            error_out_valid,
  output logic [1:0]                                      state_out
`ifdef AWG_PLAYBACK_MARKER_EN
  ,
  output logic                                            marker_out
`endif
);

  localparam int ROW_W = CHANNELS * PARALLEL_SAMPLES * SAMPLE_WIDTH;
  localparam int BEATS = ROW_W / AXI_MM_WIDTH;
  localparam int AW    = $clog2(DEPTH);

  if (BEATS < 1 || (ROW_W % AXI_MM_WIDTH) != 0) begin : g_bad_width
    $error("row width must be a positive multiple of the DMA beat width");
  end

  awg_state_t       state_q, state_d;
  logic [AW:0]      wcnt_q, wcnt_d, len_q, len_d, wcnt_base;
  logic             ovf_q, ovf_d, ovf_base;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_act_q, burst_act_d, rep_q, rep_d;
  logic             err_v_q, err_v_d;
  logic [1:0]       err_q, err_d, flags;

  logic             accept, start, stop, loading, full_rows, mem_we;
  logic             flush, issue, rd_last;
  logic             row_wr, partial;
  logic [ROW_W-1:0] row_data;

  logic [ROW_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0] rd_q1, rd_q2, out_q;
  logic             v1_q, v2_q, out_v_q;

  assign accept    = dma_in_valid && (state_q != PLAYING);
  assign stop      = trigger_in_valid && trigger_in_data[TRIG_STOP];
  assign start     = trigger_in_valid && trigger_in_data[TRIG_START] && !stop;
  assign loading   = (state_q == LOADING);
  assign wcnt_base = loading ? wcnt_q : '0;
  assign ovf_base  = loading && ovf_q;
  assign full_rows = (wcnt_base == (AW+1)'(DEPTH));
  assign mem_we    = row_wr && !full_rows;
  assign flush     = (state_q == PLAYING) && stop;
  assign issue     = (state_q == PLAYING) && !stop;
  assign rd_last   = ({1'b0, rd_addr_q} == len_q - (AW+1)'(1));

  dma_row_packer #(
    .ROW_W (ROW_W),
    .AXI_W (AXI_MM_WIDTH)
  ) u_packer (
    .clk           (clk),
    .reset         (reset),
    .beat_data_i   (dma_in_data),
    .beat_accept_i (accept),
    .beat_last_i   (dma_in_last),
    .row_wr_o      (row_wr),
    .row_data_o    (row_data),
    .partial_o     (partial)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    rd_addr_d   = rd_addr_q;
    rep_d       = rep_q;
    burst_act_d = burst_act_q;
    err_v_d     = 1'b0;
    err_d       = '0;
    flags       = '0;
    if (state_q == PLAYING) begin
      if (stop) begin
        state_d = READY;
      end else if (rd_last) begin
        rd_addr_d = '0;
        rep_d     = rep_q + BURST_WIDTH'(1);
        if (burst_act_q != '0 && rep_d == burst_act_q) state_d = READY;
      end else begin
        rd_addr_d = rd_addr_q + AW'(1);
      end
    end else if (accept) begin
      // A fresh load restarts at row 0 and invalidates the old waveform.
      state_d = LOADING;
      if (!loading) len_d = '0;
      wcnt_d = wcnt_base + (AW+1)'(mem_we);
      ovf_d  = ovf_base || full_rows;
      if (dma_in_last) begin
        flags[ERR_OVERFLOW] = ovf_d;
        flags[ERR_PARTIAL]  = partial;
        len_d   = wcnt_d;
        err_v_d = |flags;
        err_d   = flags;
        state_d = READY;
      end
    end else if (state_q == READY && start) begin
      state_d     = PLAYING;
      rd_addr_d   = '0;
      rep_d       = '0;
      burst_act_d = burst_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      rd_addr_q   <= '0;
      rep_q       <= '0;
      burst_q     <= BURST_WIDTH'(1);
      burst_act_q <= BURST_WIDTH'(1);
      err_v_q     <= 1'b0;
      err_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_v_q     <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      rd_addr_q   <= rd_addr_d;
      rep_q       <= rep_d;
      burst_act_q <= burst_act_d;
      err_v_q     <= err_v_d;
      err_q       <= err_d;
      if (burst_in_valid) burst_q <= burst_in_data;
      // Stop kills everything still in flight through the read pipeline.
      v1_q    <= issue;
      v2_q    <= v1_q && !flush;
      out_v_q <= v2_q && !flush;
      out_q   <= (v2_q && !flush) ? rd_q2 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wcnt_base[AW-1:0]] <= row_data;
    rd_q1 <= mem[rd_addr_q];
    rd_q2 <= rd_q1;
  end

`ifdef AWG_PLAYBACK_MARKER_EN
  logic mk1_q, mk2_q, mk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mk1_q <= 1'b0;
      mk2_q <= 1'b0;
      mk_q  <= 1'b0;
    end else begin
      mk1_q <= issue && (rd_addr_q == '0);
      mk2_q <= mk1_q && !flush;
      mk_q  <= mk2_q && !flush;
    end
  end

  assign marker_out = mk_q;
`endif

  assign dma_in_ready    = (state_q != PLAYING);
  assign dac_out_data    = out_q;
  assign dac_out_valid   = {CHANNELS{out_v_q}};
  assign error_out_valid = err_v_q;
  assign error_out_data  = err_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_awg_playback_buffer.sv
// tb/tb_awg_playback_buffer.sv - directed self-checking bench for awg_playback_buffer
module tb_awg_playback_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dma_in_data = '0;
  logic        dma_in_valid = 1'b0;
  logic        dma_in_last = 1'b0;
  logic        dma_in_ready;
  logic [63:0] dac_out_data;
  logic [1:0]  dac_out_valid;
  logic [1:0]  trigger_in_data = '0;
  logic        trigger_in_valid = 1'b0;
  logic [15:0] burst_in_data = '0;
  logic        burst_in_valid = 1'b0;
  logic [1:0]  error_out_data;
  logic        error_out_valid;
  logic [1:0]  state_out;

  int          tests = 0;
  int          fails = 0;
  logic        got_ev;
  logic [1:0]  got_ed;
  logic [63:0] exp_rows[$];

  awg_playback_buffer #(
    .CHANNELS         (2),
    .DEPTH            (8),
    .AXI_MM_WIDTH     (32),
    .PARALLEL_SAMPLES (2),
    .SAMPLE_WIDTH     (16),
    .BURST_WIDTH      (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dma_in_data      (dma_in_data),
    .dma_in_valid     (dma_in_valid),
    .dma_in_last      (dma_in_last),
    .dma_in_ready     (dma_in_ready),
    .dac_out_data     (dac_out_data),
    .dac_out_valid    (dac_out_valid),
    .trigger_in_data  (trigger_in_data),
    .trigger_in_valid (trigger_in_valid),
    .burst_in_data    (burst_in_data),
    .burst_in_valid   (burst_in_valid),
    .error_out_data   (error_out_data),
    .error_out_valid  (error_out_valid),
    .state_out        (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rowv(input logic [31:0] base, input int r);
    return {base + 32'(2*r + 1), base + 32'(2*r)};
  endfunction

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dma_in_valid = 1'b1;
      dma_in_data  = base + 32'(i);
      dma_in_last  = (i == n - 1);
      @(posedge clk);
    end
    @(negedge clk);
    dma_in_valid = 1'b0;
    dma_in_last  = 1'b0;
    got_ev = error_out_valid;
    got_ed = error_out_data;
  endtask

  task automatic set_burst(input logic [15:0] v);
    @(negedge clk);
    burst_in_valid = 1'b1;
    burst_in_data  = v;
    @(negedge clk);
    burst_in_valid = 1'b0;
  endtask

  // Returns at the falling edge just after the strobe was sampled.
  task automatic trig(input logic [1:0] d);
    @(negedge clk);
    trigger_in_valid = 1'b1;
    trigger_in_data  = d;
    @(negedge clk);
    trigger_in_valid = 1'b0;
    trigger_in_data  = '0;
  endtask

  task automatic run_burst(input string tag);
    trig(2'b01);
    @(negedge clk);
    check({tag, "_state_play"}, state_out, 2'd3);
    check({tag, "_ready_play"}, dma_in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_latency"}, dac_out_valid, 2'b00);
    foreach (exp_rows[i]) begin
      @(negedge clk);
      check({tag, "_row"}, dac_out_data, exp_rows[i]);
      check({tag, "_valid"}, dac_out_valid, 2'b11);
    end
    @(negedge clk);
    check({tag, "_valid_end"}, dac_out_valid, 2'b00);
    check({tag, "_data_end"}, dac_out_data, 64'h0);
    check({tag, "_state_end"}, state_out, 2'd2);
  endtask

  initial begin
    @(negedge clk);
    check("rst_state", state_out, 2'd0);
    check("rst_ready", dma_in_ready, 1'b1);
    check("rst_valid", dac_out_valid, 2'b00);
    check("rst_data", dac_out_data, 64'h0);
    check("rst_err_v", error_out_valid, 1'b0);
    check("rst_err_d", error_out_data, 2'b00);
    reset = 1'b0;

    trig(2'b01);
    @(negedge clk);
    check("idle_start_ignored", state_out, 2'd0);

    // Full 4-row waveform, one pass.
    set_burst(16'd1);
    load(8, 32'h0);
    check("t1_err_v", got_ev, 1'b0);
    check("t1_state", state_out, 2'd2);
    exp_rows = {};
    for (int r = 0; r < 4; r++) exp_rows.push_back(rowv(32'h0, r));
    run_burst("t1");

    // Partial last row is zero padded.
    load(3, 32'h2);
    check("t2_err_v", got_ev, 1'b1);
    check("t2_err_d", got_ed, 2'b10);
    @(negedge clk);
    check("t2_err_pulse", error_out_valid, 1'b0);
    exp_rows = {64'h0000_0003_0000_0002, 64'h0000_0000_0000_0004};
    run_burst("t2");

    // Overflow: 10 rows offered, only 8 kept.
    load(20, 32'h10);
    check("t3_err_v", got_ev, 1'b1);
    check("t3_err_d", got_ed, 2'b01);
    exp_rows = {};
    for (int r = 0; r < 8; r++) exp_rows.push_back(rowv(32'h10, r));
    run_burst("t3");

    // Infinite burst, wrap without bubble, then stop.
    set_burst(16'd0);
    trig(2'b01);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k < 3) check("t4_latency", dac_out_valid, 2'b00);
      else begin
        check("t4_row", dac_out_data, rowv(32'h10, (k - 3) % 8));
        check("t4_valid", dac_out_valid, 2'b11);
      end
    end
    trigger_in_valid = 1'b1;
    trigger_in_data  = 2'b10;
    @(negedge clk);
    trigger_in_valid = 1'b0;
    trigger_in_data  = '0;
    check("t4_stop_valid", dac_out_valid, 2'b00);
    check("t4_stop_data", dac_out_data, 64'h0);
    check("t4_stop_state", state_out, 2'd2);
    check("t4_stop_ready", dma_in_ready, 1'b1);
    @(negedge clk);
    check("t4_flushed", dac_out_valid, 2'b00);

    // Start and stop together: stop wins.
    trig(2'b11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_state", state_out, 2'd2);
      check("t5_valid", dac_out_valid, 2'b00);
    end

    // Reset in the middle of playback.
    trig(2'b01);
    repeat (5) @(negedge clk);
    check("t6_pre_row", dac_out_data, rowv(32'h10, 2));
    reset = 1'b1;
    #1;
    check("t6_rst_valid", dac_out_valid, 2'b00);
    check("t6_rst_data", dac_out_data, 64'h0);
    check("t6_rst_state", state_out, 2'd0);
    check("t6_rst_ready", dma_in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    trig(2'b01);
    repeat (3) @(negedge clk);
    check("t6_start_ignored_state", state_out, 2'd0);
    check("t6_start_ignored_valid", dac_out_valid, 2'b00);

    // Length 1, burst 3: row 0 held for exactly 3 cycles.
    set_burst(16'd3);
    load(2, 32'hA);
    check("t7_err_v", got_ev, 1'b0);
    exp_rows = {64'h0000_000B_0000_000A, 64'h0000_000B_0000_000A, 64'h0000_000B_0000_000A};
    run_burst("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
